// File: rtl/simeck_pkg.sv
// Shared Simeck32/64 definitions: word width, round constant,
// LFSR seed, the round nonlinearity f(), and the controller states.
package simeck_pkg;

  localparam int WORD = 16;

  localparam logic [WORD-1:0] SIMECK_C  = 16'hFFFC;
  localparam logic [4:0]      LFSR_INIT = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXPAND = 3'd1,
    S_KEYED  = 3'd2,
    S_DEC    = 3'd3,
    S_OUT    = 3'd4
  } state_e;

  // f(x) = (x & rotl(x,5)) ^ rotl(x,1)
  function automatic logic [WORD-1:0] simeck_f(
    input logic [WORD-1:0] x
  );
    return (x & {x[10:0], x[15:11]}) ^ {x[14:0], x[15]};
  endfunction

  // z0 sequence, s[i+5] = s[i+2] ^ s[i]; bit 0 is the
  // current z, bit j holds s[i+j].
  function automatic logic [4:0] lfsr_step(
    input logic [4:0] s
  );
    return {s[2] ^ s[0], s[4:1]};
  endfunction

endpackage

// File: rtl/simeck32_round.sv
// One combinational Simeck32 round. Forward: {l,r} -> {r^f(l)^k, l}.
// Ports: blk_i {l,r}, k_i round key, blk_o result. INV=1 undoes a round.
module simeck32_round
  import simeck_pkg::*;
#(
  parameter bit INV = 1'b0
) (
  input  logic [31:0]     blk_i,
  input  logic [WORD-1:0] k_i,
  output logic [31:0]     blk_o
);

  logic [WORD-1:0] l, r;

  assign l = blk_i[31:16];
  assign r = blk_i[15:0];

  always_comb begin
    blk_o = '0;
    if (INV) begin
      blk_o = {r, l ^ simeck_f(r) ^ k_i};
    end else begin
      blk_o = {r ^ simeck_f(l) ^ k_i, l};
    end
  end

endmodule

// File: rtl/simeck32_dec_ctrl.sv
// Iterative Simeck32/64 decryptor: expands a key into a round-key
// buffer, then runs ROUNDS inverse rounds per block, keys reversed.
// Ports: clk, rst (sync, active-low), key_in/key_load/key_valid,
// ct_in/in_valid/in_ready, pt_out/out_valid/out_ready, busy.
module simeck32_dec_ctrl
  import simeck_pkg::*;
#(
  parameter int ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        key_load,
  output logic        key_valid,
  input  logic [31:0] ct_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] pt_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int CW = $clog2(ROUNDS);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_e state_q, state_d;

  logic [CW-1:0]   cnt_q;
  logic [4:0]      lfsr_q;
  logic [WORD-1:0] w0_q, w1_q, w2_q, w3_q;
  logic [WORD-1:0] l_q, r_q;
  logic [31:0]     pt_q;
  logic            out_valid_q;
  logic            key_valid_q;
  logic [WORD-1:0] rk_q [ROUNDS];

  logic            cnt_last;
  logic            key_start;
  logic            accept;
  logic [CW-1:0]   rd_idx;
  logic [31:0]     exp_blk;
  logic [31:0]     dec_blk;

  assign cnt_last = (cnt_q == LAST);
  assign rd_idx   = LAST - cnt_q;

  // Key expansion reuses the forward round with k = C ^ z:
  // upper half of the result is the next schedule word.
  simeck32_round #(.INV(1'b0)) u_exp (
    .blk_i (
      {w1_q, w0_q}),
    .k_i   (SIMECK_C ^ {15'b0, lfsr_q[0]}),
    .blk_o (exp_blk)
  );

  simeck32_round #(.INV(1'b1)) u_dec (
    .blk_i ({l_q, r_q}),
    .k_i   (rk_q[rd_idx]),
    .blk_o (dec_blk)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    key_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        key_start = key_load;
        if (key_load) state_d = S_EXPAND;
      end
      S_EXPAND: begin
        busy = 1'b1;
        if (cnt_last) state_d = S_KEYED;
      end
      S_KEYED: begin
        key_start = key_load;
        in_ready  = !key_load;
        if (key_load)      state_d = S_EXPAND;
        else if (in_valid) state_d = S_DEC;
      end
      S_DEC: begin
        busy = 1'b1;
        if (cnt_last) state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_KEYED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      lfsr_q      <= LFSR_INIT;
      w0_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      w3_q        <= '0;
      l_q         <= '0;
      r_q         <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      unique case (1'b1)
        key_start: begin
          {w3_q, w2_q, w1_q, w0_q} <= key_in;
          lfsr_q      <= LFSR_INIT;
          cnt_q       <= '0;
          key_valid_q <= 1'b0;
        end
        accept: begin
          {l_q, r_q} <= ct_in;
          cnt_q      <= '0;
        end
        (state_q == S_EXPAND): begin
          w0_q   <= exp_blk[15:0];
          w1_q   <= w2_q;
          w2_q   <= w3_q;
          w3_q   <= exp_blk[31:16];
          lfsr_q <= lfsr_step(lfsr_q);
          cnt_q  <= cnt_last ? '0 : cnt_q + ONE;
          if (cnt_last) key_valid_q <= 1'b1;
        end
        (state_q == S_DEC): begin
          {l_q, r_q} <= dec_blk;
          cnt_q      <= cnt_last ? '0 : cnt_q + ONE;
          if (cnt_last) begin
            pt_q        <= dec_blk;
            out_valid_q <= 1'b1;
          end
        end
        (state_q == S_OUT): begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Schedule storage survives reset; key_valid guards its use.
  always_ff @(posedge clk) begin
    if (state_q == S_EXPAND) rk_q[cnt_q] <= w0_q;
  end

  assign key_valid = key_valid_q;
  assign out_valid = out_valid_q;
  assign pt_out    = pt_q;

endmodule

// File: tb/tb_simeck32_dec_ctrl.sv
// Directed bench for simeck32_dec_ctrl: block table plus reset,
// backpressure, ignored key_load and mid-block reset sequences.
module tb_simeck32_dec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        key_load;
  logic        key_valid;
  logic [31:0] ct_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pt_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_pass = 0;
  int n_tot  = 0;

  simeck32_dec_ctrl #(.ROUNDS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_load  (key_load),
    .key_valid (key_valid),
    .ct_in     (ct_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt_out    (pt_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] key;
    logic [31:0] ct;
    logic [31:0] pt;
    int          hold;
    int          kl;
  } vec_t;

  localparam logic [63:0] K1 = 64'h1918_1110_0908_0100;
  localparam logic [63:0] K2 = 64'h0123_4567_89ab_cdef;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [15:0] mf(input logic [15:0] x);
    return (x & ((x << 5) | (x >> 11))) ^ ((x << 1) | (x >> 15));
  endfunction

  // Forward Simeck32/64 encryption with the reference z0 constant.
  function automatic logic [31:0] enc(input logic [63:0] key,
                                      input logic [31:0] pt);
    logic [15:0] k0, k1, k2, k3, l, r, t;
    logic [31:0] seq;
    seq = 32'h9A42BB1F;
    {k3, k2, k1, k0} = key;
    l = pt[31:16];
    r = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t  = l;
      l  = r ^ mf(l) ^ k0;
      r  = t;
      t  = k0 ^ mf(k1) ^ 16'hFFFC ^ {15'd0, seq[i]};
      k0 = k1;
      k1 = k2;
      k2 = k3;
      k3 = t;
    end
    return {l, r};
  endfunction

  // Starts and ends on a negedge.
  task automatic load_key(input logic [63:0] key, input bit with_iv);
    int n;
    int bsy;
    key_in   = key;
    key_load = 1'b1;
    in_valid = with_iv;
    ct_in    = $urandom;
    #1;
    if (with_iv) chk("in_ready_during_keyload", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    key_load = 1'b0;
    in_valid = 1'b0;
    n   = 0;
    bsy = 0;
    while (!key_valid && n < 100) begin
      if (busy) bsy++;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("key_valid_latency", 64'(n), 64'd32);
    chk("busy_during_expand", 64'(bsy), 64'd32);
    chk("out_valid_after_expand", 64'(out_valid), 64'd0);
  endtask

  task automatic run_block(input logic [31:0] ct, input logic [31:0] exp,
                           input int hold, input int kl);
    int n;
    int bad;
    logic [31:0] snap;
    ct_in    = ct;
    in_valid = 1'b1;
    #1;
    chk("in_ready_keyed", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ct_in    = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin
      key_load = (n == kl);
      if (n == kl) key_in = 64'hFFFF_0000_AAAA_5555;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    key_load = 1'b0;
    chk("dec_latency", 64'(n), 64'd32);
    chk("pt_out", 64'(pt_out), 64'(exp));
    snap = pt_out;
    bad  = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || pt_out !== snap || in_ready) bad++;
    end
    if (hold > 0) chk("backpressure_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_cleared", 64'(out_valid), 64'd0);
    chk("in_ready_after_out", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] cur_key;
    int bad;

    vecs[0] = '{K1, 32'h770d2c76, 32'h65656877, 0, -1};
    vecs[1] = '{K1, enc(K1, 32'h0000_0000), 32'h0000_0000, 10, -1};
    vecs[2] = '{K1, enc(K1, 32'hFFFF_FFFF), 32'hFFFF_FFFF, 2, 5};
    vecs[3] = '{K2, enc(K2, 32'h1234_5678), 32'h1234_5678, 1, -1};
    vecs[4] = '{K2, enc(K2, 32'h6565_6877), 32'h6565_6877, 0, 20};
    vecs[5] = '{K1, 32'h770d2c76, 32'h65656877, 3, -1};

    rst       = 1'b0;
    key_in    = {$urandom, $urandom};
    key_load  = 1'($urandom);
    ct_in     = $urandom;
    in_valid  = 1'($urandom);
    out_ready = 1'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_key_valid", 64'(key_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pt_out", 64'(pt_out), 64'd0);
    rst       = 1'b1;
    key_load  = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    load_key(K1, 1'b0);
    cur_key = K1;

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].key !== cur_key) begin
        load_key(vecs[v].key, 1'b1);
        cur_key = vecs[v].key;
      end
      run_block(vecs[v].ct, vecs[v].pt, vecs[v].hold, vecs[v].kl);
    end

    ct_in    = 32'h770d2c76;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("busy_mid_dec", 64'(busy), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_key_valid", 64'(key_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (in_ready || out_valid || busy) bad++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("refused_after_rst", 64'(bad), 64'd0);
    load_key(K1, 1'b0);
    run_block(32'h770d2c76, 32'h65656877, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
